// File: rtl/or_bus_timer_pkg.sv
// Shared definitions for the OR-bus timer: register word offsets and CTRL bit positions.
// Firmware headers and the bench use the same names.
package or_bus_timer_pkg;

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_PRESCALE = 2'd1,
    REG_COUNT    = 2'd2,
    REG_COMPARE  = 2'd3
  } reg_addr_e;

  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_AUTORELOAD_BIT = 1;
  localparam int CTRL_IE_BIT         = 2;
  localparam int CTRL_PENDING_BIT    = 3;

endpackage

// File: rtl/or_bus_timer_if.sv
// Data-bus connection between the MCU core (master) and the timer slave.
// ReadData from several slaves is OR-merged, so an unselected slave must drive zero.
interface or_bus_timer_if;
  logic        Select;
  logic        WriteEnable;
  logic [1:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output Select, output WriteEnable, output Address, output WriteData,
                  input ReadData);
  modport slave  (input Select, input WriteEnable, input Address, input WriteData,
                  output ReadData);
endinterface

// File: rtl/or_bus_timer_prescaler.sv
// Prescaler: counts 0..limit while enabled and pulses tick in the cycle it reaches limit.
// Held at zero while disabled; clr restarts it from zero.
module or_bus_timer_prescaler #(
  parameter int PrescaleBits = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic [PrescaleBits-1:0] limit_i,
  output logic                    tick_o
);

  localparam logic [PrescaleBits-1:0] ONE = PrescaleBits'(1);

  logic [PrescaleBits-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == limit_i);
    cnt_d  = cnt_q + ONE;
    if (!en_i || clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/or_bus_timer_slave.sv
// Memory-mapped 32-bit timer on the OR-merged MCU data bus: CTRL, PRESCALE, COUNT, COMPARE.
// Define OR_BUS_TIMER_IRQ_EN to implement the IE bit and drive Irq; otherwise Irq is tied low.
module or_bus_timer_slave
  import or_bus_timer_pkg::*;
#(
  parameter int NrOfBits     = 32,
  parameter int PrescaleBits = 16
) (
  input  logic             GlobalClock,
  input  logic             Reset,
  or_bus_timer_if.slave    bus,
  output logic             Irq
);

  localparam logic [NrOfBits-1:0] ONE = NrOfBits'(1);

  logic                    en_q, en_d;
  logic                    ar_q, ar_d;
  logic                    pend_q, pend_d;
  logic [PrescaleBits-1:0] presc_q, presc_d;
  logic [NrOfBits-1:0]     count_q, count_d;
  logic [NrOfBits-1:0]     cmp_q, cmp_d;
  logic                    ie_q;
  logic                    wr, tick, match, presc_clr;
  reg_addr_e               addr;

  assign addr      = reg_addr_e'(bus.Address);
  assign wr        = bus.Select && bus.WriteEnable;
  assign presc_clr = wr && (addr == REG_PRESCALE);
  assign match     = tick && (count_q == cmp_q);

  or_bus_timer_prescaler #(.PrescaleBits(PrescaleBits)) u_prescaler (
    .clk_i   (GlobalClock),
    .rst_i   (Reset),
    .en_i    (en_q),
    .clr_i   (presc_clr),
    .limit_i (presc_q),
    .tick_o  (tick)
  );

  // Bus writes are applied after the tick update so that a COUNT write overrides the increment.
  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    pend_d  = pend_q || match;
    presc_d = presc_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    if (tick) count_d = (match && ar_q) ? '0 : count_q + ONE;
    if (wr) begin
      case (addr)
        REG_CTRL: begin
          en_d = bus.WriteData[CTRL_EN_BIT];
          ar_d = bus.WriteData[CTRL_AUTORELOAD_BIT];
          if (bus.WriteData[CTRL_PENDING_BIT] && !match) pend_d = 1'b0;
        end
        REG_PRESCALE: presc_d = bus.WriteData[PrescaleBits-1:0];
        REG_COUNT:    count_d = bus.WriteData[NrOfBits-1:0];
        REG_COMPARE:  cmp_d   = bus.WriteData[NrOfBits-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge GlobalClock or posedge Reset) begin
    if (Reset) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      pend_q  <= 1'b0;
      presc_q <= '0;
      count_q <= '0;
      cmp_q   <= '1;
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      pend_q  <= pend_d;
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
    end
  end

`ifdef OR_BUS_TIMER_IRQ_EN
  logic ie_d;
  always_comb begin
    ie_d = ie_q;
    if (wr && addr == REG_CTRL) ie_d = bus.WriteData[CTRL_IE_BIT];
  end

  always_ff @(posedge GlobalClock or posedge Reset) begin
    if (Reset) ie_q <= 1'b0;
    else       ie_q <= ie_d;
  end

  assign Irq = pend_q && ie_q;
`else
  assign ie_q = 1'b0;
  assign Irq  = 1'b0;
`endif

  // Zero unless this slave is addressed for a read: the bus ORs all slaves together.
  always_comb begin
    bus.ReadData = '0;
    if (bus.Select && !bus.WriteEnable) begin
      case (addr)
        REG_CTRL:     bus.ReadData = {28'd0, pend_q, ie_q, ar_q, en_q};
        REG_PRESCALE: bus.ReadData = 32'(presc_q);
        REG_COUNT:    bus.ReadData = 32'(count_q);
        REG_COMPARE:  bus.ReadData = 32'(cmp_q);
        default:      bus.ReadData = '0;
      endcase
    end
  end

endmodule
